// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way set-associative cache controller.
//   state_e  : controller FSM states
//   NUM_WAYS : associativity (two ways; one LRU bit per set)
package cache_pkg;

  localparam int NUM_WAYS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cache_way_array.sv
// Storage for one cache way: per-set valid, dirty, tag and data.
// Reads are combinational at idx_i; writes happen on the rising clock edge
// when we_i is high and update all four fields of set idx_i together.
// Only valid/dirty are cleared by reset; tag and data keep their contents.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   idx_i                set index (shared by read and write)
//   valid_o .. data_o    line contents at idx_i
//   we_i                 write enable
//   wr_valid_i .. wr_data_i  values written at idx_i
import cache_pkg::*;

module cache_way_array #(
  parameter int SETS   = 4,
  parameter int IDX_W  = 2,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic              valid_o,
  output logic              dirty_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              we_i,
  input  logic              wr_valid_i,
  input  logic              wr_dirty_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      valid_q[idx_i] <= wr_valid_i;
      dirty_q[idx_i] <= wr_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[idx_i]  <= wr_tag_i;
      data_q[idx_i] <= wr_data_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign data_o  = data_q[idx_i];

endmodule

// File: rtl/cache_ctrl_2way.sv
// 2-way set-associative, write-back, write-allocate cache controller with
// one word per line and one LRU bit per set.
// Optional feature: define CACHE_STATS_EN to add 16-bit hit/miss counters.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   cpu_req/we/addr/wdata      CPU request, sampled only in IDLE
//   cpu_rdata, cpu_ready       completion pulse and read data
//   mem_req/we/addr/wdata      backing-memory request, held until mem_ack
//   mem_rdata, mem_ack         backing-memory response
//   hit_cnt, miss_cnt          (CACHE_STATS_EN only) completed hits/misses
module cache_ctrl_2way
  import cache_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SETS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef CACHE_STATS_EN
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W;

  state_e state_q, state_d;
  logic [SETS-1:0] lru_q, lru_d;

  // captured request and miss bookkeeping
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              victim_q, victim_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;

  logic [NUM_WAYS-1:0] rd_valid;
  logic [NUM_WAYS-1:0] rd_dirty;
  logic [TAG_W-1:0]    rd_tag  [NUM_WAYS];
  logic [DATA_W-1:0]   rd_data [NUM_WAYS];

  logic [NUM_WAYS-1:0] way_we;
  logic                wr_valid;
  logic                wr_dirty;
  logic [TAG_W-1:0]    wr_tag;
  logic [DATA_W-1:0]   wr_data;

  logic [NUM_WAYS-1:0] hit;
  logic                hit_way;
  logic                victim_sel;

  assign idx = addr_q[IDX_W-1:0];
  assign tag = addr_q[ADDR_W-1:IDX_W];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    cache_way_array #(
      .SETS   (SETS),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_way (
      .clk_i      (clk),
      .rst_i      (rst),
      .idx_i      (idx),
      .valid_o    (rd_valid[w]),
      .dirty_o    (rd_dirty[w]),
      .tag_o      (rd_tag[w]),
      .data_o     (rd_data[w]),
      .we_i       (way_we[w]),
      .wr_valid_i (wr_valid),
      .wr_dirty_i (wr_dirty),
      .wr_tag_i   (wr_tag),
      .wr_data_i  (wr_data)
    );
  end

  always_comb begin
    for (int w = 0; w < NUM_WAYS; w++) begin
      hit[w] = rd_valid[w] && (rd_tag[w] == tag);
    end
  end

  // way0 wins if both somehow match
  assign hit_way = ~hit[0];

  // an empty way is always preferred over evicting; way0 before way1
  assign victim_sel = !rd_valid[0] ? 1'b0 :
                      !rd_valid[1] ? 1'b1 : lru_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      lru_q   <= lru_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && cpu_req) begin
      we_q    <= cpu_we;
      addr_q  <= cpu_addr;
      wdata_q <= cpu_wdata;
    end
    victim_q <= victim_d;
    rdata_q  <= rdata_d;
  end

  always_comb begin
    state_d   = state_q;
    lru_d     = lru_q;
    victim_d  = victim_q;
    rdata_d   = rdata_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    way_we    = '0;
    wr_valid  = 1'b0;
    wr_dirty  = 1'b0;
    wr_tag    = '0;
    wr_data   = '0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_req) state_d = ST_LOOKUP;
      end

      ST_LOOKUP: begin
        if (|hit) begin
          cpu_ready    = 1'b1;
          cpu_rdata    = rd_data[hit_way];
          lru_d[idx]   = ~hit_way;
          if (we_q) begin
            way_we[hit_way] = 1'b1;
            wr_valid        = 1'b1;
            wr_dirty        = 1'b1;
            wr_tag          = tag;
            wr_data         = wdata_q;
          end
          state_d = ST_IDLE;
        end else begin
          victim_d = victim_sel;
          if (rd_valid[victim_sel] && rd_dirty[victim_sel]) state_d = ST_WRITEBACK;
          else if (we_q)                                    state_d = ST_DONE;
          else                                              state_d = ST_REFILL;
        end
      end

      ST_WRITEBACK: begin
        // victim line is read live; nothing writes this set until the ack
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {rd_tag[victim_q], idx};
        mem_wdata = rd_data[victim_q];
        if (mem_ack) state_d = we_q ? ST_DONE : ST_REFILL;
      end

      ST_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) begin
          way_we[victim_q] = 1'b1;
          wr_valid         = 1'b1;
          wr_dirty         = 1'b0;
          wr_tag           = tag;
          wr_data          = mem_rdata;
          rdata_d          = mem_rdata;
          state_d          = ST_DONE;
        end
      end

      ST_DONE: begin
        cpu_ready  = 1'b1;
        cpu_rdata  = we_q ? wdata_q : rdata_q;
        lru_d[idx] = ~victim_q;
        // write-allocate without refill: the new word lands here, dirty
        if (we_q) begin
          way_we[victim_q] = 1'b1;
          wr_valid         = 1'b1;
          wr_dirty         = 1'b1;
          wr_tag           = tag;
          wr_data          = wdata_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic        hit_evt;
  logic        miss_evt;
  logic [15:0] hit_cnt_q;
  logic [15:0] miss_cnt_q;

  assign hit_evt  = (state_q == ST_LOOKUP) && (|hit);
  assign miss_evt = (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Self-checking bench for cache_ctrl_2way (ADDR_W=8, DATA_W=8, SETS=4).
// A functional cache model plus a backing-memory array predict every
// memory transaction, read value and hit latency.
module tb_cache_ctrl_2way;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int SETS   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
`ifdef CACHE_STATS_EN
  logic [15:0]       hit_cnt;
  logic [15:0]       miss_cnt;
`endif

  always #5 clk = ~clk;

  cache_ctrl_2way #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .SETS   (SETS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
`ifdef CACHE_STATS_EN
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt),
`endif
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  int checks = 0;
  int errors = 0;

  // functional model
  bit         m_valid [SETS][2];
  bit         m_dirty [SETS][2];
  logic [5:0] m_tag   [SETS][2];
  logic [7:0] m_data  [SETS][2];
  bit         m_lru   [SETS];
  logic [7:0] tbmem   [256];
  int         exp_hits;
  int         exp_misses;

  // prediction for the current request
  bit         e_hit;
  int         e_nops;
  logic       e_op_we   [2];
  logic [7:0] e_op_addr [2];
  logic [7:0] e_op_wd   [2];
  logic [7:0] e_rdata;

  // observations from the last request
  int         last_ops;
  int         last_lat;
  logic [7:0] last_rdata;
  logic       obs_we   [4];
  logic [7:0] obs_addr [4];
  logic [7:0] obs_wd   [4];

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    exp_hits   = 0;
    exp_misses = 0;
  endtask

  task automatic model_access(input bit we, input logic [7:0] a, input logic [7:0] wd);
    int         s;
    int         hw;
    int         v;
    logic [5:0] t;
    s      = int'(a[1:0]);
    t      = a[7:2];
    hw     = -1;
    e_nops = 0;
    for (int w = 0; w < 2; w++)
      if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (hw >= 0) begin
      e_hit   = 1'b1;
      e_rdata = m_data[s][hw];
      if (we) begin
        m_data[s][hw]  = wd;
        m_dirty[s][hw] = 1'b1;
      end
      m_lru[s] = (hw == 0);
      exp_hits++;
    end else begin
      e_hit = 1'b0;
      exp_misses++;
      if (!m_valid[s][0])      v = 0;
      else if (!m_valid[s][1]) v = 1;
      else                     v = int'(m_lru[s]);
      if (m_valid[s][v] && m_dirty[s][v]) begin
        e_op_we[e_nops]   = 1'b1;
        e_op_addr[e_nops] = {m_tag[s][v], a[1:0]};
        e_op_wd[e_nops]   = m_data[s][v];
        tbmem[{m_tag[s][v], a[1:0]}] = m_data[s][v];
        e_nops++;
      end
      if (!we) begin
        e_op_we[e_nops]   = 1'b0;
        e_op_addr[e_nops] = a;
        e_op_wd[e_nops]   = 8'h00;
        e_nops++;
        e_rdata       = tbmem[a];
        m_data[s][v]  = tbmem[a];
        m_dirty[s][v] = 1'b0;
      end else begin
        e_rdata       = wd;
        m_data[s][v]  = wd;
        m_dirty[s][v] = 1'b1;
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = t;
      m_lru[s]      = (v == 0);
    end
  endtask

  // Issue one request and act as backing memory until cpu_ready.
  task automatic do_req(input bit we, input logic [7:0] a, input logic [7:0] wd,
                        input int delay, input bit noise);
    int   cyc;
    int   op;
    int   wcnt;
    bit   active;
    bit   done;
    logic       h_we;
    logic [7:0] h_addr;
    logic [7:0] h_wd;
    cyc = 0; op = 0; wcnt = 0; active = 0; done = 0;
    h_we = 1'b0; h_addr = '0; h_wd = '0;
    model_access(we, a, wd);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; mem_ack = 1'b0;
    @(negedge clk);
    while (!done && cyc < 100) begin
      cyc++;
      mem_ack = 1'b0;
      if (cpu_ready) begin
        done       = 1;
        last_ops   = op;
        last_lat   = cyc;
        last_rdata = cpu_rdata;
        checks++;
        if (mem_req !== 1'b0) begin
          errors++; $display("FAIL ready_with_mem_req addr=%h mem_req=%b expected 0", a, mem_req);
        end
        checks++;
        if (op != e_nops) begin
          errors++; $display("FAIL mem_op_count addr=%h got %0d expected %0d", a, op, e_nops);
        end
        if (!we) begin
          checks++;
          if (cpu_rdata !== e_rdata) begin
            errors++; $display("FAIL read_data addr=%h got %h expected %h", a, cpu_rdata, e_rdata);
          end
        end
        if (e_hit) begin
          checks++;
          if (cyc != 1) begin
            errors++; $display("FAIL hit_latency addr=%h got %0d expected 1", a, cyc);
          end
        end
      end else if (mem_req) begin
        if (!active) begin
          active = 1; wcnt = 0;
          h_we = mem_we; h_addr = mem_addr; h_wd = mem_wdata;
          if (op < 4) begin
            obs_we[op] = mem_we; obs_addr[op] = mem_addr; obs_wd[op] = mem_wdata;
          end
          checks++;
          if (op >= e_nops) begin
            errors++; $display("FAIL unexpected_mem_op addr=%h mem_addr=%h we=%b expected none", a, mem_addr, mem_we);
          end else if (mem_we !== e_op_we[op] || mem_addr !== e_op_addr[op] ||
                       (e_op_we[op] && mem_wdata !== e_op_wd[op])) begin
            errors++;
            $display("FAIL mem_op req=%h got we=%b addr=%h wd=%h expected we=%b addr=%h wd=%h",
                     a, mem_we, mem_addr, mem_wdata, e_op_we[op], e_op_addr[op], e_op_wd[op]);
          end
        end else begin
          checks++;
          if (mem_we !== h_we || mem_addr !== h_addr || mem_wdata !== h_wd) begin
            errors++;
            $display("FAIL mem_stable req=%h got we=%b addr=%h wd=%h held we=%b addr=%h wd=%h",
                     a, mem_we, mem_addr, mem_wdata, h_we, h_addr, h_wd);
          end
        end
        wcnt++;
        if (wcnt > delay) begin
          mem_ack   = 1'b1;
          mem_rdata = (op < e_nops) ? tbmem[e_op_addr[op]] : 8'h00;
          active    = 0;
          op++;
        end else begin
          mem_rdata = 8'($urandom);
        end
      end else if (noise) begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (done) begin
        cpu_req = 1'b0;
      end else begin
        cpu_req   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 8'($urandom);
        cpu_wdata = 8'($urandom);
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    if (!done) begin
      checks++; errors++;
      last_ops = -1; last_lat = -1;
      $display("FAIL timeout addr=%h no cpu_ready within 100 cycles", a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h04;
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0 || mem_req !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 8'h00 || mem_wdata !== 8'h00 || cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b req=%b we=%b addr=%h wd=%h rdata=%h expected all 0",
               cpu_ready, mem_req, mem_we, mem_addr, mem_wdata, cpu_rdata);
    end
    cpu_req = 1'b0;
    rst = 1'b0;
    model_reset();
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_stats got hit=%0d miss=%0d expected 0 0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_directed();
    tbmem[8'h04] = 8'hA5;
    tbmem[8'h44] = 8'h5A;
    tbmem[8'hC4] = 8'h77;
    do_req(0, 8'h04, 8'h00, 0, 0);
    checks++;
    if (last_ops != 1 || last_rdata !== 8'hA5 || obs_addr[0] !== 8'h04) begin
      errors++; $display("FAIL first_read got ops=%0d rdata=%h addr=%h expected 1 a5 04", last_ops, last_rdata, obs_addr[0]);
    end
    do_req(0, 8'h04, 8'h00, 0, 0);
    checks++;
    if (last_ops != 0 || last_lat != 1 || last_rdata !== 8'hA5) begin
      errors++; $display("FAIL reread_hit got ops=%0d lat=%0d rdata=%h expected 0 1 a5", last_ops, last_lat, last_rdata);
    end
`ifdef CACHE_STATS_EN
    checks++;
    if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
      errors++; $display("FAIL stats_after_first got hit=%0d miss=%0d expected 1 1", hit_cnt, miss_cnt);
    end
`endif
    do_req(1, 8'h84, 8'h3C, 0, 0);
    checks++;
    if (last_ops != 0) begin
      errors++; $display("FAIL write_miss_traffic got ops=%0d expected 0", last_ops);
    end
    do_req(0, 8'h04, 8'h00, 0, 0);
    do_req(0, 8'h84, 8'h00, 0, 0);
    checks++;
    if (last_rdata !== 8'h3C || last_lat != 1) begin
      errors++; $display("FAIL read_written got rdata=%h lat=%0d expected 3c 1", last_rdata, last_lat);
    end
    do_req(0, 8'h44, 8'h00, 0, 0);
    checks++;
    if (last_ops != 1 || obs_we[0] !== 1'b0) begin
      errors++; $display("FAIL clean_evict got ops=%0d we=%b expected 1 0", last_ops, obs_we[0]);
    end
    do_req(0, 8'hC4, 8'h00, 5, 0);
    checks++;
    if (last_ops != 2 || obs_we[0] !== 1'b1 || obs_addr[0] !== 8'h84 || obs_wd[0] !== 8'h3C ||
        obs_we[1] !== 1'b0 || obs_addr[1] !== 8'hC4 || last_rdata !== 8'h77) begin
      errors++;
      $display("FAIL dirty_evict got ops=%0d wb=%b/%h/%h rf=%b/%h rdata=%h expected 2 1/84/3c 0/c4 77",
               last_ops, obs_we[0], obs_addr[0], obs_wd[0], obs_we[1], obs_addr[1], last_rdata);
    end
  endtask

  task automatic test_reset_mid_refill();
    int n;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    @(negedge clk);
    cpu_req = 1'b0;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h05) begin
      errors++; $display("FAIL refill_started got req=%b we=%b addr=%h expected 1 0 05", mem_req, mem_we, mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b0 || mem_addr !== 8'h00 || cpu_rdata !== 8'h00) begin
      errors++; $display("FAIL reset_in_refill got req=%b ready=%b addr=%h rdata=%h expected 0 0 00 00",
                         mem_req, cpu_ready, mem_addr, cpu_rdata);
    end
    rst = 1'b0;
    model_reset();
    do_req(0, 8'h04, 8'h00, 0, 0);
    checks++;
    if (last_ops != 1 || obs_addr[0] !== 8'h04) begin
      errors++; $display("FAIL miss_after_reset got ops=%0d addr=%h expected 1 04", last_ops, obs_addr[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] d;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      do_req(1, a, d, $urandom_range(0, 2), 1);
      do_req(0, a, 8'h00, 0, 1);
      checks++;
      if (last_lat != 1 || last_ops != 0 || last_rdata !== d) begin
        errors++; $display("FAIL same_addr_hit addr=%h got lat=%0d ops=%0d rdata=%h expected 1 0 %h",
                           a, last_lat, last_ops, last_rdata, d);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] t;
    logic [1:0] s;
    for (int i = 0; i < 300; i++) begin
      t = 6'($urandom_range(0, 3));
      s = 2'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), {t, s}, 8'($urandom), $urandom_range(0, 3), 1);
    end
`ifdef CACHE_STATS_EN
    @(negedge clk);
    checks++;
    if (int'(hit_cnt) != exp_hits || int'(miss_cnt) != exp_misses) begin
      errors++; $display("FAIL stats_random got hit=%0d miss=%0d expected %0d %0d",
                         hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    last_ops = 0; last_lat = 0; last_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      obs_we[i] = 1'b0; obs_addr[i] = '0; obs_wd[i] = '0;
    end
    for (int i = 0; i < 256; i++) tbmem[i] = 8'($urandom);
    model_reset();
    test_reset();
    test_directed();
    test_reset_mid_refill();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_2way.md
CACHE_CTRL_2WAY -- requirements
Module: cache_ctrl_2way

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width.
REQ-002 Parameter DATA_W, default 8, data word width.
REQ-003 Parameter SETS, default 4, number of sets; power of two, >=2; IDX_W=log2(SETS), TAG_W=ADDR_W-IDX_W.
REQ-004 Port clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port cpu_req  in  1  request valid; sampled only in IDLE.
REQ-007 Port cpu_we  in  1  1=write, 0=read.
REQ-008 Port cpu_addr  in  ADDR_W  word address; index=addr[IDX_W-1:0], tag=upper TAG_W bits.
REQ-009 Port cpu_wdata  in  DATA_W  write data.
REQ-010 Port cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1.
REQ-011 Port cpu_ready  out  1  one-cycle completion pulse.
REQ-012 Port mem_req / mem_we  out  1 / 1  backing-memory request and direction.
REQ-013 Port mem_addr / mem_wdata  out  ADDR_W / DATA_W  memory address and write data.
REQ-014 Port mem_rdata / mem_ack  in  DATA_W / 1  memory read data and one-cycle completion.

Function
REQ-015 2-way set-associative, one word per line; per way and set: valid, dirty, tag, data; per set: one LRU bit naming the least-recently-used way.
REQ-016 FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, DONE.
REQ-017 IDLE: cpu_req=1 captures we/addr/wdata and goes to LOOKUP; cpu_req is ignored in every other state.
REQ-018 LOOKUP hit (valid and tag match in either way): read returns the line data; write updates data and sets dirty; LRU points to the other way; cpu_ready=1 in this cycle; next state IDLE. Hit latency is 1 cycle after acceptance.
REQ-019 LOOKUP miss victim selection: first invalid way (way0 before way1); otherwise the LRU way.
REQ-020 Victim valid and dirty: go to WRITEBACK. Otherwise a read miss goes to REFILL and a write miss goes to DONE.
REQ-021 WRITEBACK: mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim data, all held stable until mem_ack. Then a read goes to REFILL and a write goes to DONE.
REQ-022 REFILL: mem_req=1, mem_we=0, mem_addr=captured address, held until mem_ack. On mem_ack, install mem_rdata, valid=1, dirty=0; next state DONE.
REQ-023 Write miss is write-allocate with no refill: the victim receives tag, wdata, valid=1, dirty=1.
REQ-024 DONE: cpu_ready=1; cpu_rdata is the installed word (reads); LRU points away from the filled way; next state IDLE.
REQ-025 mem_ack is ignored while mem_req=0; mem_req is never asserted in IDLE, LOOKUP or DONE.
REQ-026 A request to the same address immediately after completion hits.

Reset
REQ-027 rst=1 at a clock edge, in any state including mid-WRITEBACK or mid-REFILL: FSM to IDLE, all valid/dirty/LRU bits 0, cpu_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0. The in-flight request is dropped.
REQ-028 Tag and data storage are not reset.

Configuration
REQ-029 Macro CACHE_STATS_EN defined: adds outputs hit_cnt and miss_cnt (16 bits each), reset to 0, incremented once per completed hit or miss, wrapping at 2^16.
REQ-030 Macro CACHE_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.

Structure
REQ-031 Package cache_pkg holds the FSM state enum and the constant NUM_WAYS=2.
REQ-032 Sub-module cache_way_array, instantiated once per way, holds the tag/data/valid/dirty arrays with combinational read and synchronous write.

Verification (ADDR_W=8, DATA_W=8, SETS=4)
REQ-033 After reset, read 0x04 -> REFILL with mem_addr=0x04; ack with 0xA5 -> cpu_ready, rdata=0xA5. Re-read 0x04 -> hit, ready 1 cycle after acceptance, no mem_req.
REQ-034 Write 0x84 with 0x3C -> fills way1, no memory traffic. Read 0x04 -> 0xA5 hit; read 0x84 -> 0x3C hit.
REQ-035 Read 0x44 -> evicts clean 0x04 (LRU), no writeback. Then read 0xC4 -> WRITEBACK mem_addr=0x84, mem_wdata=0x3C, mem_we=1, then REFILL 0xC4.
REQ-036 mem_ack delayed 5 cycles -> mem_req, mem_addr and mem_we stable throughout; cpu_ready stays 0.
REQ-037 rst asserted during REFILL -> mem_req=0 after that edge; a subsequent read of 0x04 misses.
REQ-038 With CACHE_STATS_EN, after REQ-033 -> hit_cnt=1, miss_cnt=1.
